// File: rtl/fwft_fifo_pkg.sv
// Shared constants and helpers for the fwft small FIFO.
// Default geometry plus occupancy-counter width helper.
package fwft_fifo_pkg;

  localparam int DEFAULT_WIDTH          = 72;
  localparam int DEFAULT_MAX_DEPTH_BITS = 3;

  // Counter must hold 0..DEPTH inclusive
  function automatic int occ_width(input int max_depth_bits);
    return max_depth_bits + 1;
  endfunction

endpackage

// File: rtl/fwft_fifo_ram.sv
// DEPTH x WIDTH storage for the fwft FIFO.
// Synchronous write, asynchronous read for fall-through.
module fwft_fifo_ram
  import fwft_fifo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_BITS = DEFAULT_MAX_DEPTH_BITS
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  // Store accepted write words
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fwft_small_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy flags.
// Optional sim checks: define FIFO_ERROR_CHECK_EN.
module fwft_small_fifo
  import fwft_fifo_pkg::*;
#(
  parameter int WIDTH               = DEFAULT_WIDTH,
  parameter int MAX_DEPTH_BITS      = DEFAULT_MAX_DEPTH_BITS,
  parameter int PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int CW    = occ_width(MAX_DEPTH_BITS);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] NF_C    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESHOLD);

  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CW-1:0]             count;
  logic [WIDTH-1:0]          rd_data;
  logic                      wr_acc;
  logic                      rd_acc;

  assign full        = (count == DEPTH_C);
  assign nearly_full = (count >= NF_C);
  assign prog_full   = (count >= PF_C);
  assign empty       = (count == '0);

  // Full/empty are taken from pre-edge occupancy
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  assign dout = empty ? '0 : rd_data;

  fwft_fifo_ram #(
    .WIDTH    (WIDTH),
    .ADDR_BITS(MAX_DEPTH_BITS)
  ) u_ram (
    .clk    (clk),
    .we     (wr_acc && !rst),
    .wr_addr(wr_ptr),
    .wr_data(din),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef FIFO_ERROR_CHECK_EN
  // Report overflow and underflow attempts
  always_ff @(posedge clk) begin
    if (!rst && wr_en && full) begin
      $display("ERROR %m: write while full (overflow) at %0t", $time);
    end
    if (!rst && rd_en && empty) begin
      $display("ERROR %m: read while empty (underflow) at %0t", $time);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fwft_small_fifo.sv
// Testbench for fwft_small_fifo (WIDTH=32, depth 16).
// Queue model checked every cycle plus literal checks.
module tb_fwft_small_fifo;

  localparam int W   = 32;
  localparam int MDB = 4;
  localparam int D   = 16;
  localparam int PFT = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] dout;
  logic         full;
  logic         nearly_full;
  logic         prog_full;
  logic         empty;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  logic [W-1:0] q [$];

  fwft_small_fifo #(
    .WIDTH              (W),
    .MAX_DEPTH_BITS     (MDB),
    .PROG_FULL_THRESHOLD(PFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .nearly_full(nearly_full),
    .prog_full  (prog_full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Behavioural model: FIFO queue with pre-edge full/empty rules
  always @(posedge clk) begin
    bit w_ok;
    bit r_ok;
    if (rst) begin
      q.delete();
    end else begin
      w_ok = wr_en && (q.size() < D);
      r_ok = rd_en && (q.size() > 0);
      if (r_ok) void'(q.pop_front());
      if (w_ok) q.push_back(din);
    end
  end

  // Compare DUT against model every cycle
  always @(negedge clk) begin
    if (armed) begin
      check("m_empty", W'(empty), W'(q.size() == 0));
      check("m_full", W'(full), W'(q.size() == D));
      check("m_nfull", W'(nearly_full), W'(q.size() >= D - 1));
      check("m_pfull", W'(prog_full), W'(q.size() >= PFT));
      check("m_dout", dout, (q.size() == 0) ? '0 : q[0]);
    end
  end

  task automatic tick(input logic w, input logic r,
                      input logic [W-1:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tick(0, 0, '0);
    armed = 1'b1;
    tick(0, 0, '0);
    rst = 1'b0;
    tick(0, 0, '0);
    check("rst_empty", W'(empty), 1);
    check("rst_full", W'(full), 0);
    check("rst_nfull", W'(nearly_full), 0);
    check("rst_pfull", W'(prog_full), 0);
    check("rst_dout", dout, 0);

    tick(1, 0, 32'h0001_00AA);
    check("wr1_empty", W'(empty), 0);
    check("wr1_dout", dout, 32'h0001_00AA);
    tick(0, 1, '0);
    check("rd1_empty", W'(empty), 1);
    check("rd1_dout", dout, 0);

    for (int i = 0; i < 16; i++) begin
      tick(1, 0, W'(i));
      if (i == 11) check("pf_at12", W'(prog_full), 1);
      if (i == 13) check("nf_at14", W'(nearly_full), 0);
      if (i == 14) begin
        check("nf_at15", W'(nearly_full), 1);
        check("full_at15", W'(full), 0);
      end
    end
    check("full_at16", W'(full), 1);
    tick(1, 0, 32'hDEAD);
    check("ovf_full", W'(full), 1);
    check("ovf_head", dout, 0);
    for (int i = 0; i < 16; i++) begin
      check("drain16", dout, W'(i));
      tick(0, 1, '0);
    end
    check("drain_empty", W'(empty), 1);
    check("drain_dout", dout, 0);

    for (int i = 0; i < 8; i++) tick(1, 0, W'(100 + i));
    for (int i = 0; i < 20; i++) begin
      check("ss_head", dout,
            (i < 8) ? W'(100 + i) : W'(200 + i - 8));
      tick(1, 1, W'(200 + i));
      check("ss_nf", W'(nearly_full), 0);
    end
    for (int i = 12; i < 20; i++) begin
      check("ss_tail", dout, W'(200 + i));
      tick(0, 1, '0);
    end
    check("ss_empty", W'(empty), 1);

    for (int i = 0; i < 16; i++) tick(1, 0, W'(300 + i));
    check("fb_full0", W'(full), 1);
    tick(1, 1, 32'hBEEF);
    check("fb_full", W'(full), 0);
    check("fb_nfull", W'(nearly_full), 1);
    check("fb_head", dout, 301);
    for (int i = 1; i < 16; i++) begin
      check("fb_drain", dout, W'(300 + i));
      tick(0, 1, '0);
    end
    check("fb_empty", W'(empty), 1);
    tick(1, 1, 32'h55);
    check("eb_empty", W'(empty), 0);
    check("eb_dout", dout, 32'h55);
    tick(0, 1, '0);
    check("eb_drain", W'(empty), 1);

    for (int i = 0; i < 5; i++) tick(1, 0, W'(400 + i));
    rst = 1'b1;
    tick(1, 0, 32'h77);
    rst = 1'b0;
    check("mr_empty", W'(empty), 1);
    check("mr_dout", dout, 0);
    tick(0, 1, '0);
    check("mr_still", W'(empty), 1);
    tick(1, 0, 32'h99);
    check("mr_wr", dout, 32'h99);
    check("mr_pf", W'(prog_full), 0);
    tick(0, 1, '0);
    check("mr_rd", W'(empty), 1);
    tick(0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
